// File: rtl/prm_oblgc_scan.sv
// prm_oblgc_scan: initiator side of the edge-obstacle checker.
// Walks a code range, packs mask bits into words, streams them out.
module prm_oblgc_scan #(
    parameter int CODE_W  = 15,
    parameter int CHK_LAT = 1,
    parameter int WORD_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [CODE_W-1:0] start_code,
    input  logic [CODE_W-1:0] end_code,
    output logic [CODE_W-1:0] chk_code,
    input  logic              chk_mask,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WORD_W-1:0] res_data,
    output logic [CODE_W-1:0] res_base,
    output logic              res_last,
    output logic              busy,
    output logic              done
);

    localparam int IW = $clog2(WORD_W);
    localparam logic [IW:0] LAST_IDX = (IW+1)'(WORD_W - 1);
    localparam logic [CODE_W:0] ONE = (CODE_W+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        LAST
    } state_t;

    state_t state;
    state_t state_next;

    logic accept;
    logic issuing;
    logic xfer;
    logic finish;
    logic word_end;
    logic out_free;
    logic inflight;
    logic land;
    logic [IW-1:0] land_idx;

    logic [CODE_W:0]   span;
    logic [CODE_W:0]   rem;
    logic [IW:0]       word_cnt;
    logic [CODE_W-1:0] word_base;
    logic [WORD_W-1:0] acc;

    // Codes in the inclusive range, wrapping through the top code.
    assign span = {1'b0, end_code - start_code} + 1'b1;

    assign word_end = (word_cnt == LAST_IDX) || (rem == ONE);
    assign out_free = !res_valid || res_ready;

    assign start_ready = (state == IDLE) && !rst;
    assign busy        = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issuing    = 1'b0;
        xfer       = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_valid) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                issuing = 1'b1;
                if (word_end) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (!inflight && out_free) begin
                    xfer = 1'b1;
                    if (rem == '0) begin
                        state_next = LAST;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            LAST: begin
                if (res_valid && res_ready) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Issue pointer: chk_code always shows the code being issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_code  <= '0;
            word_base <= '0;
            rem       <= '0;
            word_cnt  <= '0;
        end else if (accept) begin
            chk_code  <= start_code;
            word_base <= start_code;
            rem       <= span;
            word_cnt  <= '0;
        end else if (issuing) begin
            rem      <= rem - 1'b1;
            word_cnt <= word_cnt + 1'b1;
            if (!word_end) begin
                chk_code <= chk_code + 1'b1;
            end
        end else if (xfer) begin
            word_cnt <= '0;
            if (rem != '0) begin
                chk_code  <= chk_code + 1'b1;
                word_base <= chk_code + 1'b1;
            end
        end
    end

    // Result alignment: carry the bit index alongside the checker latency.
    if (CHK_LAT == 0) begin : g_direct
        assign land     = issuing;
        assign land_idx = word_cnt[IW-1:0];
        assign inflight = 1'b0;
    end else begin : g_pipe
        logic [CHK_LAT-1:0] pv;
        logic [IW-1:0]      pi [CHK_LAT];

        // Delay line of issue valid and bit index.
        always_ff @(posedge clk) begin
            if (rst) begin
                pv <= '0;
                for (int i = 0; i < CHK_LAT; i++) begin
                    pi[i] <= '0;
                end
            end else begin
                pv[0] <= issuing;
                pi[0] <= word_cnt[IW-1:0];
                for (int i = 1; i < CHK_LAT; i++) begin
                    pv[i] <= pv[i-1];
                    pi[i] <= pi[i-1];
                end
            end
        end

        assign land     = pv[CHK_LAT-1];
        assign land_idx = pi[CHK_LAT-1];
        assign inflight = |pv;
    end

    // Accumulator collects landed mask bits; clears on hand-off.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (xfer) begin
            acc <= '0;
        end else if (land) begin
            acc[land_idx] <= chk_mask;
        end
    end

    // Output register; may empty and reload in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_base  <= '0;
            res_last  <= 1'b0;
        end else if (xfer) begin
            res_valid <= 1'b1;
            res_data  <= acc;
            res_base  <= word_base;
            res_last  <= (rem == '0);
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // Completion pulse after the final word leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= finish;
        end
    end

endmodule

// File: tb/tb_prm_oblgc_scan.sv
// tb_prm_oblgc_scan: randomized bench with a word-level scoreboard.
// Directed scans pin the model with hand-computed words.
module tb_prm_oblgc_scan;

    localparam int CW  = 15;
    localparam int LAT = 1;
    localparam int WW  = 32;

    typedef struct {
        logic [WW-1:0] data;
        logic [CW-1:0] base;
        logic          last;
    } word_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [CW-1:0] start_code = '0;
    logic [CW-1:0] end_code = '0;
    logic [CW-1:0] chk_code;
    logic          chk_mask = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [WW-1:0] res_data;
    logic [CW-1:0] res_base;
    logic          res_last;
    logic          busy;
    logic          done;

    bit    tbl [0:32767];
    int    mode = 0;
    int    rr_mode = 0;
    int    n_vec = 0;
    int    n_err = 0;
    word_t exp_q [$];
    word_t got_q [$];
    logic  rst_q = 1'b1;
    bit    m_busy = 1'b0;
    bit    m_done = 1'b0;

    prm_oblgc_scan #(
        .CODE_W (CW),
        .CHK_LAT(LAT),
        .WORD_W (WW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .start_code (start_code),
        .end_code   (end_code),
        .chk_code   (chk_code),
        .chk_mask   (chk_mask),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_base   (res_base),
        .res_last   (res_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic bit chkf(input logic [CW-1:0] c, input int md);
        case (md)
            0: return 1'b1;
            1: return c[0];
            2: return (c == 15'h7FFF) || (c == 15'h0000);
            default: return tbl[c];
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    // Expected words of one scan, straight from the range arithmetic.
    task automatic push_scan(input logic [CW-1:0] s, input logic [CW-1:0] e,
                             input int md);
        logic [CW-1:0] d;
        int cnt;
        int nw;
        word_t w;
        d = e - s;
        cnt = int'(d) + 1;
        nw = (cnt + WW - 1) / WW;
        for (int k = 0; k < nw; k++) begin
            w.base = s + CW'(k * WW);
            w.data = '0;
            for (int i = 0; i < WW; i++) begin
                if (k * WW + i < cnt) begin
                    w.data[i] = chkf(w.base + CW'(i), md);
                end
            end
            w.last = (k == nw - 1);
            exp_q.push_back(w);
        end
    endtask

    // Checker model with one cycle of latency.
    always @(posedge clk) chk_mask <= chkf(chk_code, mode);

    always @(posedge clk) rst_q <= rst;

    // Downstream ready pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0: res_ready = 1'b1;
                1: res_ready = 1'($urandom_range(0, 1));
                default: res_ready = 1'b0;
            endcase
        end
    end

    // Compare process: checks every cycle, then advances the model.
    always @(negedge clk) begin : cmp
        word_t w;
        if (rst_q) begin
            chk("rst_busy", busy, 0);
            chk("rst_valid", res_valid, 0);
            chk("rst_code", chk_code, 0);
            chk("rst_data", res_data, 0);
            chk("rst_base", res_base, 0);
            chk("rst_last", res_last, 0);
            chk("rst_done", done, 0);
            if (rst) chk("rst_ready", start_ready, 0);
        end else begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("start_ready", start_ready, !m_busy && !rst);
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_word: got base %0h, required none",
                             res_base);
                end else begin
                    chk("res_data", res_data, exp_q[0].data);
                    chk("res_base", res_base, exp_q[0].base);
                    chk("res_last", res_last, exp_q[0].last);
                end
            end
        end
        if (rst) begin
            exp_q.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (start_valid && !m_busy) begin
                push_scan(start_code, end_code, mode);
                m_busy = 1'b1;
            end
            if (res_valid && res_ready && exp_q.size() > 0) begin
                w.data = res_data;
                w.base = res_base;
                w.last = res_last;
                got_q.push_back(w);
                if (exp_q[0].last) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || rst) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 5000) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0",
                     busy, n);
        end
    endtask

    task automatic start_scan(input logic [CW-1:0] s, input logic [CW-1:0] e,
                              input int md);
        wait_idle();
        mode = md;
        start_code = s;
        end_code = e;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    task automatic chk_word(input string nm, input int idx,
                            input logic [WW-1:0] d, input logic [CW-1:0] b,
                            input logic l);
        if (got_q.size() > idx) begin
            chk({nm, "_data"}, got_q[idx].data, d);
            chk({nm, "_base"}, got_q[idx].base, b);
            chk({nm, "_last"}, got_q[idx].last, l);
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got no word, required word %0d", nm, idx);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        int gi;
        int n;
        logic [CW-1:0] s;
        int cnt;
        for (int i = 0; i < 32768; i++) tbl[i] = 1'($urandom);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        rr_mode = 0;
        gi = got_q.size();
        start_scan(15'h1234, 15'h1234, 0);
        wait_idle();
        chk_word("single", gi, 32'h0000_0001, 15'h1234, 1'b1);

        gi = got_q.size();
        start_scan(15'h0000, 15'h001F, 1);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (res_valid) break;
            n++;
        end
        chk("latency", n, 34);
        wait_idle();
        chk_word("parity", gi, 32'hAAAA_AAAA, 15'h0000, 1'b1);

        gi = got_q.size();
        start_scan(15'h0000, 15'h0020, 0);
        wait_idle();
        chk_word("two_w0", gi, 32'hFFFF_FFFF, 15'h0000, 1'b0);
        chk_word("two_w1", gi + 1, 32'h0000_0001, 15'h0020, 1'b1);

        gi = got_q.size();
        start_scan(15'h7FFE, 15'h0001, 2);
        wait_idle();
        chk_word("wrap", gi, 32'h0000_0006, 15'h7FFE, 1'b1);

        rr_mode = 2;
        gi = got_q.size();
        start_scan(15'h0000, 15'h007F, 3);
        n = 0;
        while (!res_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            start_valid = (k == 20);
            start_code = 15'h0500;
            end_code = 15'h0520;
        end
        start_valid = 1'b0;
        chk("stall_code", chk_code, 15'h003F);
        chk("stall_valid", res_valid, 1);
        chk("stall_base", res_base, 15'h0000);
        rr_mode = 0;
        wait_idle();
        chk("stall_words", got_q.size() - gi, 4);
        for (int k = 0; k < 4; k++) begin
            if (got_q.size() > gi + k) begin
                chk("stall_order", got_q[gi+k].base, 32 * k);
            end
        end

        start_scan(15'h0100, 15'h013F, 0);
        n = 0;
        while (!res_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        gi = got_q.size();
        start_scan(15'h2000, 15'h2004, 1);
        wait_idle();
        chk_word("after_rst", gi, 32'h0000_000A, 15'h2000, 1'b1);

        for (int t = 0; t < 20; t++) begin
            s = (t == 0) ? 15'h7FF0 : CW'($urandom);
            cnt = $urandom_range(1, 150);
            rr_mode = $urandom_range(0, 1);
            start_scan(s, s + CW'(cnt - 1), $urandom_range(0, 3));
            repeat ($urandom_range(1, 10)) @(posedge clk);
            #1;
            if (busy) begin
                start_code = CW'($urandom);
                end_code = start_code + 15'd3;
                start_valid = 1'b1;
                @(posedge clk);
                #1;
                start_valid = 1'b0;
            end
            wait_idle();
        end

        rr_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("leftover", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
